bcp_scheduler: RTL
==================

Name: bcp_scheduler

Overview:
- Sequences Boolean constraint propagation over a clause memory using a single bcp_checker1 instance.
- Per clause: fetches the clause, computes the false-literal count, issues it to the checker and applies any returned implication to the working assignment.
- Repeats full passes until a pass produces no implication (fixpoint) or a clause is fully falsified (conflict).
- Sits between the decision/backtrack engine (start/done side) and the clause RAM plus checker (datapath side).

Parameters:
- var_num, 8, number of variables; width of assignment/free/clause vectors.
- clause_num, 16, number of clauses in clause memory.
- addr_w, 4, clause address width; must satisfy 2^addr_w >= clause_num.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; latches assignment_in/free_in and begins BCP; ignored while busy.
- assignment_in  in  var_num  initial variable values (valid where free_in=0).
- free_in  in  var_num  1 = variable unassigned.
- clause_addr  out  addr_w  clause RAM read address.
- clause_rd  out  1  read strobe; data valid exactly 1 cycle later.
- clause_type_in  in  var_num  literal polarity; literal is true when assignment bit == type bit.
- clause_mask_in  in  var_num  1 = variable present in clause.
- clause_size_in  in  var_num  number of literals in clause.
- chk_en  out  1  one-cycle issue pulse to the checker.
- chk_free, chk_assignment, chk_clause_type, chk_clause_mask, chk_clause_size, chk_counter  out  var_num each  checker operands, held stable from issue until chk_finish.
- chk_unit_exist  in  1  checker found a unit clause.
- chk_implication  in  var_num  one-hot implied variable.
- chk_finish  in  1  checker result valid.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of BCP.
- conflict  out  1  valid with done; holds its value until the next start.
- assignment_out, free_out  out  var_num  working assignment; updated live, final at done.
- imp_count  out  8  implications applied since start; saturates at 255.

Behaviour:
- Reset values: every output is 0. FSM goes to IDLE. Reset asserted mid-operation aborts immediately, with no done pulse.
- FSM states: IDLE, FETCH, LOAD, ISSUE, WAIT, UPDATE, PASS_END, FINISH.
- IDLE: on start, latch assignment/free, addr=0, changed=0, imp_count=0, clear conflict, then go to FETCH.
- FETCH: clause_rd=1 for one cycle, then LOAD.
- LOAD: capture clause fields and compute false_cnt = popcount(mask & ~free & (assignment ^ type)).
  - If mask==0, skip to UPDATE with no issue.
  - Else if false_cnt == size, set conflict and go to FINISH.
  - Else go to ISSUE.
- ISSUE: chk_en=1 for exactly one cycle, chk_counter=false_cnt, then WAIT.
- WAIT: hold all chk_* operands. On chk_finish go to UPDATE. No timeout.
- UPDATE:
  - If chk_unit_exist and chk_implication is one-hot, on a free, masked bit:
    - set assignment bit to the clause_type bit;
    - clear the free bit;
    - set changed=1;
    - increment imp_count.
  - A non-one-hot or non-free implication is ignored.
  - If addr == clause_num-1, go to PASS_END; else addr+1 and FETCH.
- PASS_END: if changed, clear changed, set addr=0, go to FETCH; else go to FINISH.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Later clauses in the same pass see assignments updated by earlier clauses.
- Minimum per-clause latency: FETCH+LOAD+ISSUE+WAIT(1)+UPDATE = 5 cycles.
- start arriving on the same cycle as FINISH is ignored; it is accepted only in IDLE.
- Termination: each productive pass assigns at least one free variable, so there are at most var_num+1 passes.

Decomposition:
- Shared package bcp_pkg holds:
  - the state encoding localparams;
  - default var_num/clause_num;
  - a popcount function for the false-literal counter.
- One natural sub-module: bcp_false_counter, a combinational masked popcount that is registered in LOAD.
- The checker itself stays external.

Test Plan:
- Single clause (x0 ∨ x1), var_num=8, type=00000011, mask=00000011, size=2; x1 assigned 0, x0 free.
  - Required: one issue with chk_counter=1; checker returns implication=00000001.
  - Required: assignment_out[0]=1, free_out[0]=0, imp_count=1.
  - Required: a second pass runs with no change, then done with conflict=0.
- Chain: clause A (¬x2 ∨ x3), clause B (¬x3 ∨ x4), x2=1, all others free.
  - Required: x3=1 and x4=1 in the first pass; imp_count=2.
  - Required: two passes total before done.
- Conflict: clause mask=00000011, type=00000011, size=2, with x0=0 and x1=0 both assigned.
  - Required: chk_en never pulses; done with conflict=1 at clause index 0.
- Empty clause mask=00000000 at address 3.
  - Required: no chk_en for address 3; the pass continues to address 4.
- Reset asserted while in WAIT.
  - Required: next cycle busy=0, done=0, all outputs 0, state IDLE.
  - Required: a subsequent start runs normally.
- start pulsed while busy=1 with different assignment_in.
  - Required: ignored; the final assignment_out reflects the original start operands.

Source files
------------

// File: rtl/bcp_pkg.sv
// Shared types and helpers for the BCP scheduler: FSM state encoding, default sizes
// and the popcount used by the false-literal counter.
package bcp_pkg;

    localparam int unsigned VarNumDefault    = 8;
    localparam int unsigned ClauseNumDefault = 16;
    localparam int unsigned MaxVarNum        = 64;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StLoad    = 3'd2,
        StIssue   = 3'd3,
        StWait    = 3'd4,
        StUpdate  = 3'd5,
        StPassEnd = 3'd6,
        StFinish  = 3'd7
    } bcp_state_e;

    function automatic int unsigned popcount(input logic [MaxVarNum-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MaxVarNum; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/bcp_false_counter.sv
// Combinational count of literals in a clause that are assigned and evaluate false.
module bcp_false_counter
    import bcp_pkg::*;
#(
    parameter int unsigned var_num = VarNumDefault
) (
    input  logic [var_num-1:0] assignment_i,
    input  logic [var_num-1:0] free_i,
    input  logic [var_num-1:0] type_i,
    input  logic [var_num-1:0] mask_i,
    output logic [var_num-1:0] false_cnt_o
);

    logic [MaxVarNum-1:0] false_lits;

    always_comb begin
        false_lits              = '0;
        false_lits[var_num-1:0] = mask_i & ~free_i & (assignment_i ^ type_i);
        false_cnt_o             = var_num'(popcount(false_lits));
    end

endmodule

// File: rtl/bcp_scheduler.sv
// Walks the clause memory issuing each clause to an external checker, applying returned
// implications, and repeats passes until a fixpoint or a falsified clause.
module bcp_scheduler
    import bcp_pkg::*;
#(
    parameter int unsigned var_num    = VarNumDefault,
    parameter int unsigned clause_num = ClauseNumDefault,
    parameter int unsigned addr_w     = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [var_num-1:0] assignment_in,
    input  logic [var_num-1:0] free_in,
    output logic [addr_w-1:0]  clause_addr,
    output logic               clause_rd,
    input  logic [var_num-1:0] clause_type_in,
    input  logic [var_num-1:0] clause_mask_in,
    input  logic [var_num-1:0] clause_size_in,
    output logic               chk_en,
    output logic [var_num-1:0] chk_free,
    output logic [var_num-1:0] chk_assignment,
    output logic [var_num-1:0] chk_clause_type,
    output logic [var_num-1:0] chk_clause_mask,
    output logic [var_num-1:0] chk_clause_size,
    output logic [var_num-1:0] chk_counter,
    input  logic               chk_unit_exist,
    input  logic [var_num-1:0] chk_implication,
    input  logic               chk_finish,
    output logic               busy,
    output logic               done,
    output logic               conflict,
    output logic [var_num-1:0] assignment_out,
    output logic [var_num-1:0] free_out,
    output logic [7:0]         imp_count
);

    bcp_state_e state_q, state_d;

    logic [addr_w-1:0]  addr_q, addr_d;
    logic               changed_q, changed_d;
    logic               conflict_q, conflict_d;
    logic [7:0]         imp_count_q, imp_count_d;
    logic [var_num-1:0] assign_q, assign_d;
    logic [var_num-1:0] free_q, free_d;
    logic [var_num-1:0] ctype_q, ctype_d;
    logic [var_num-1:0] cmask_q, cmask_d;
    logic [var_num-1:0] csize_q, csize_d;
    logic [var_num-1:0] fcnt_q, fcnt_d;
    logic               unit_q, unit_d;
    logic [var_num-1:0] imp_q, imp_d;

    logic [var_num-1:0] false_cnt;
    logic               imp_onehot;
    logic               imp_apply;

    bcp_false_counter #(
        .var_num(var_num)
    ) u_false_counter (
        .assignment_i(assign_q),
        .free_i      (free_q),
        .type_i      (clause_type_in),
        .mask_i      (clause_mask_in),
        .false_cnt_o (false_cnt)
    );

    // The checker's result is latched in WAIT so UPDATE does not depend on it staying valid.
    assign imp_onehot = (imp_q != '0) && ((imp_q & (imp_q - var_num'(1))) == '0);
    assign imp_apply  = unit_q && imp_onehot && ((imp_q & free_q & cmask_q) != '0);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        changed_d   = changed_q;
        conflict_d  = conflict_q;
        imp_count_d = imp_count_q;
        assign_d    = assign_q;
        free_d      = free_q;
        ctype_d     = ctype_q;
        cmask_d     = cmask_q;
        csize_d     = csize_q;
        fcnt_d      = fcnt_q;
        unit_d      = unit_q;
        imp_d       = imp_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    assign_d    = assignment_in;
                    free_d      = free_in;
                    addr_d      = '0;
                    changed_d   = 1'b0;
                    imp_count_d = '0;
                    conflict_d  = 1'b0;
                    state_d     = StFetch;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                ctype_d = clause_type_in;
                cmask_d = clause_mask_in;
                csize_d = clause_size_in;
                fcnt_d  = false_cnt;
                unit_d  = 1'b0;
                imp_d   = '0;
                if (clause_mask_in == '0) begin
                    state_d = StUpdate;
                end else if (false_cnt == clause_size_in) begin
                    conflict_d = 1'b1;
                    state_d    = StFinish;
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (chk_finish) begin
                    unit_d  = chk_unit_exist;
                    imp_d   = chk_implication;
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                if (imp_apply) begin
                    assign_d  = (assign_q & ~imp_q) | (ctype_q & imp_q);
                    free_d    = free_q & ~imp_q;
                    changed_d = 1'b1;
                    if (imp_count_q != 8'hFF) begin
                        imp_count_d = imp_count_q + 8'd1;
                    end
                end
                if (addr_q == addr_w'(clause_num - 1)) begin
                    state_d = StPassEnd;
                end else begin
                    addr_d  = addr_q + addr_w'(1);
                    state_d = StFetch;
                end
            end
            StPassEnd: begin
                if (changed_q) begin
                    changed_d = 1'b0;
                    addr_d    = '0;
                    state_d   = StFetch;
                end else begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            changed_q   <= 1'b0;
            conflict_q  <= 1'b0;
            imp_count_q <= '0;
            assign_q    <= '0;
            free_q      <= '0;
            ctype_q     <= '0;
            cmask_q     <= '0;
            csize_q     <= '0;
            fcnt_q      <= '0;
            unit_q      <= 1'b0;
            imp_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            changed_q   <= changed_d;
            conflict_q  <= conflict_d;
            imp_count_q <= imp_count_d;
            assign_q    <= assign_d;
            free_q      <= free_d;
            ctype_q     <= ctype_d;
            cmask_q     <= cmask_d;
            csize_q     <= csize_d;
            fcnt_q      <= fcnt_d;
            unit_q      <= unit_d;
            imp_q       <= imp_d;
        end
    end

    assign clause_addr     = addr_q;
    assign clause_rd       = (state_q == StFetch);
    assign chk_en          = (state_q == StIssue);
    assign chk_free        = free_q;
    assign chk_assignment  = assign_q;
    assign chk_clause_type = ctype_q;
    assign chk_clause_mask = cmask_q;
    assign chk_clause_size = csize_q;
    assign chk_counter     = fcnt_q;
    assign busy            = (state_q != StIdle) && (state_q != StFinish);
    assign done            = (state_q == StFinish);
    assign conflict        = conflict_q;
    assign assignment_out  = assign_q;
    assign free_out        = free_q;
    assign imp_count       = imp_count_q;

endmodule
